apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between N_REQ internal requesters, e.g. the SPI register-programming agent and a debug/CSR agent.
- Arbitrates round-robin, sequences the APB SETUP and ACCESS phases, and inserts wait states on PREADY.
- Returns read data and error status to the winning requester.
- Bounds every transfer with a PREADY timeout so a hung slave cannot lock the bus.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, maximum ACCESS cycles before forced termination; 0 disables the timeout

Ports:
PCLK  input  1  APB clock; the only clock
PRESET  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester transfer request
req_write  input  N_REQ  per-requester direction (1 = write)
req_addr  input  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*DATA_W  packed write data
req_ready  output  N_REQ  one-hot pulse: request accepted and captured
rsp_valid  output  N_REQ  one-hot pulse: transfer complete for requester i
rsp_rdata  output  DATA_W  read data, valid while rsp_valid
rsp_err  output  1  PSLVERR or timeout, valid while rsp_valid
PADDR  output  ADDR_W  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  DATA_W  APB write data
PRDATA  input  DATA_W  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error

Behaviour:
- Clocking and reset:
  - Single clock PCLK; all state updates on its rising edge.
  - PRESET is synchronous, active-high.
  - Reset values: state IDLE, all outputs 0, timeout counter 0, round-robin pointer selects requester 0 as highest priority.
- States: IDLE, SETUP, ACCESS.
- IDLE / arbitration (also applies in the ACCESS completion cycle):
  - Winner is the first set req_valid bit searching from (last_grant+1) mod N_REQ.
  - req_ready[winner] is driven combinationally in the arbitration cycle.
  - On that edge: capture addr, wdata and write into PADDR, PWDATA and PWRITE; last_grant <= winner; state -> SETUP.
  - With no request, stay in IDLE.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditionally -> ACCESS after 1 cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - The timeout counter increments each cycle PREADY=0.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle; they change only at a capture edge.
- Completion (ACCESS and PREADY=1):
  - Next cycle: rsp_valid[granted] pulses for exactly 1 cycle, rsp_rdata = PRDATA (0 for writes), rsp_err = PSLVERR.
  - Counter clears.
  - If any req_valid is set in the completion cycle, re-arbitrate in that same cycle and go ACCESS -> SETUP, so PSEL stays high and PENABLE drops for 1 cycle.
  - Otherwise -> IDLE, with PSEL=0 next cycle.
- Timeout (TIMEOUT_CYC>0, counter == TIMEOUT_CYC-1, PREADY=0):
  - Terminate the transfer and go -> IDLE; PSEL and PENABLE deassert next cycle.
  - Next cycle: rsp_valid[granted] pulses with rsp_err=1 and rsp_rdata=0.
  - No back-to-back re-arbitration on a timeout cycle.
- Requesters must hold req_valid and payload stable until req_ready; dropping req_valid early withdraws the request without error.
- A requester may assert req_valid again for its next transfer before rsp_valid arrives. It is arbitrated normally but granted only when the arbiter reaches IDLE or a completion cycle.
- Minimum latency:
  - req_valid to req_ready: 0 cycles when idle.
  - Capture to first ACCESS cycle: 2 cycles.
  - Zero-wait transfer: rsp_valid 3 cycles after capture.
- PRESET asserted mid-transfer: PSEL and PENABLE go to 0 on that edge, the in-flight transfer is dropped, and no rsp_valid is issued.
- Simultaneous req_valid from all requesters: strict rotation; each requester is served once per N_REQ grants.

Decomposition:
- Package apb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  - defaults for ADDR_W and DATA_W;
  - the function that computes the timeout counter width, clog2(TIMEOUT_CYC+1), minimum 1.
- Sub-module apb_rr_picker:
  - inputs: request vector and last_grant;
  - outputs: one-hot winner and winner index;
  - purely combinational, reused by other arbiters.

Test Plan:
- Single write, req 0 addr 0x0000_0010 data 0xA5A5_0001, PREADY=1 -> req_ready[0] in cycle 0; SETUP cycle 1; ACCESS cycle 2; rsp_valid[0] cycle 3, rsp_err=0; PADDR and PWDATA stable cycles 1-2.
- Read with 3 wait states, req 1 addr 0x24, PRDATA 0xDEAD_BEEF -> 4 ACCESS cycles; rsp_valid[1] with rsp_rdata=0xDEAD_BEEF.
- req 0 and req 1 both asserted continuously for 4 transfers from reset -> grant order 0,1,0,1; PSEL held high between transfers; PENABLE low for 1 cycle between each.
- PREADY held 0 with TIMEOUT_CYC=16 -> exactly 16 ACCESS cycles; PSEL=0 next cycle; rsp_valid pulse with rsp_err=1, rsp_rdata=0; next request then completes normally.
- PSLVERR=1 with PREADY on a write -> rsp_err=1 for that requester only; the following transfer shows rsp_err=0.
- PRESET pulsed during the 2nd ACCESS cycle of a wait-stated read -> PSEL=0 and PENABLE=0 next edge; no rsp_valid; after reset, a req 1 pending alongside req 0 is granted req 0 first.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types, width defaults and helpers for the APB master arbiter
package apb_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Width of the ACCESS-cycle counter; a disabled timeout still gets a 1-bit counter.
   function automatic int cnt_width(input int timeout_cyc);
      int w;
      w = $clog2(timeout_cyc + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus signal bundle with master and slave views
interface apb_master_arbiter_if
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [ADDR_W-1:0] PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_rr_picker.sv
// rtl/apb_rr_picker.sv - combinational round-robin picker, searching upward from last_grant+1
module apb_rr_picker #(
   parameter int N_REQ = 2,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             found
);

   always_comb begin
      int j;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         j = (int'(last_grant) + i) % N_REQ;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sharing of one APB master port between N_REQ requesters
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_write,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_wdata,
   output logic [N_REQ-1:0]         req_ready,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   apb_master_arbiter_if.master     apb
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT_CYC);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [N_REQ-1:0]  win;
   logic [IDX_W-1:0]  win_idx;
   logic              win_found;
   logic              done, timeout, arb_en;
   logic [N_REQ-1:0]  grant_oh;

   apb_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req        (req_valid),
      .last_grant (last_q),
      .gnt        (win),
      .gnt_idx    (win_idx),
      .found      (win_found)
   );

   // Arbitration runs when idle and in a completion cycle, giving back-to-back SETUP.
   always_comb begin
      done      = (state_q == ACCESS) && apb.PREADY;
      timeout   = (TIMEOUT_CYC > 0) && (state_q == ACCESS) && !apb.PREADY
                  && (int'(cnt_q) == TIMEOUT_CYC - 1);
      arb_en    = (state_q == IDLE) || done;
      req_ready = (arb_en && win_found) ? win : '0;
      grant_oh  = N_REQ'(1) << last_q;
   end

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      unique case (state_q)
         IDLE: ;
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (apb.PREADY) begin
               rsp_valid_d = grant_oh;
               rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
               rsp_err_d   = apb.PSLVERR;
               cnt_d       = '0;
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
            end else if (timeout) begin
               rsp_valid_d = grant_oh;
               rsp_err_d   = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
            end else if (TIMEOUT_CYC > 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (arb_en && win_found) begin
         state_d   = SETUP;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = req_write[win_idx];
         paddr_d   = req_addr[win_idx*ADDR_W +: ADDR_W];
         pwdata_d  = req_wdata[win_idx*DATA_W +: DATA_W];
         last_d    = win_idx;
      end
   end

   // Reset points last_grant at the top requester so requester 0 wins first.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         last_q      <= IDX_W'(N_REQ - 1);
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;

endmodule
